game_tick_scheduler: RTL and testbench
======================================

// Module: game_tick_scheduler
// PURPOSE
//   Multi-channel game-timing generator for the VGA snake design. Detects one frame event per
//   frame from the scan position and derives NUM_CH independent periodic tick pulses, each with
//   a runtime-programmable period in frames (e.g. ch0 snake move, ch1 food blink).
//   Adds pause, single-frame step, per-channel disable and a free-running frame counter.
//   Sits between the VGA timing generator and the game logic / renderer.
// PARAMETERS
//   BIT      10   width of x_pos / y_pos
//   V_EVENT  490  y_pos value of the frame-event point
//   H_EVENT  656  x_pos value of the frame-event point
//   NUM_CH   2    number of tick channels (>=1)
//   CNT_W    8    width of each per-channel period and frame counter
//   FRAME_W  16   width of the free-running frame counter
// PORTS
//   clk          in   1             system clock
//   reset        in   1             synchronous, active-high reset
//   x_pos        in   BIT           current horizontal scan position
//   y_pos        in   BIT           current vertical scan position
//   period       in   NUM_CH*CNT_W  channel i period in frames = period[i*CNT_W +: CNT_W]; 0 = disabled
//   pause        in   1             level; 1 freezes all channel counters
//   step         in   1             one-cycle pulse; requests one tick on all enabled channels while paused
//   frame_strobe out  1             one-cycle pulse per frame event
//   tick         out  NUM_CH        one-cycle tick pulse per channel
//   frame_cnt    out  FRAME_W       number of frame events since reset, wraps modulo 2^FRAME_W
// BEHAVIOUR
//   - Reset: reset is synchronous, active-high; clock is clk. frame_strobe=0, tick=0,
//     frame_cnt=0, all channel counters=0, step_pending=0, match_q=1.
//   - match = (y_pos==V_EVENT && x_pos==H_EVENT); match_q <= match every cycle.
//   - frame_evt = match & ~match_q: rising-edge qualified, so exactly one event per frame even
//     when the coordinates hold for several clk cycles (pixel-enable operation).
//   - match_q resets to 1: coordinates already matching at reset release do not fire.
//     The first event needs match to drop and rise again.
//   - Latency: coordinates first match in cycle N -> frame_strobe and tick high in cycle N+1,
//     each for exactly one cycle.
//   - frame_cnt increments on every frame_evt, regardless of pause. Wraps all-ones -> 0.
//   - Per channel i on frame_evt with pause=0, period sampled in that cycle (P):
//     P==0         -> cnt<=0, no tick.
//     cnt >= P-1   -> cnt<=0, tick[i]<=1.
//     otherwise    -> cnt<=cnt+1.
//     Period P>0 gives one tick every P frames. Lowering P below the current count fires at the
//     next frame event. Period changes between events have no other effect.
//   - pause=1: channel counters hold and tick stays 0 on frame events, except for a pending step.
//   - step sampled while pause=1 sets step_pending. A step with pause=0 is ignored.
//     Further steps while pending do not queue; one pending step max.
//   - Frame event with pause=1 and step_pending=1 (including a step in the same cycle as the
//     event): every channel with P>0 ticks once and its cnt<=0; step_pending<=0.
//   - pause falling to 0 clears step_pending. Counting resumes from the held counts.
//   - No state machine beyond run/paused(+pending). All counter arithmetic is unsigned CNT_W,
//     compare on P-1 with P>0 only (no underflow).
//   - Reset mid-operation overrides everything in the same cycle. No tick is emitted in the cycle
//     after reset is asserted.
// TESTING
//   1. period={ch1=0,ch0=2}, 6 frame events -> tick[0] on events 2,4,6; tick[1] never; frame_cnt=6.
//   2. Coordinates held at (656,490) for 4 clk -> exactly one frame_strobe, high one cycle after first match.
//   3. ch0 period=5, after 3 events set period=1 -> tick[0] on next event, then every event.
//   4. pause=1 for 3 events -> no ticks, frame_cnt still +3.
//      Then step pulse -> single tick on all enabled channels at next event. Second step before
//      that event -> still one tick.
//   5. Reset released with coordinates matching -> no strobe. Coordinates leave and return -> strobe, frame_cnt=1.
//   6. FRAME_W=4, 17 events -> frame_cnt=1. Assert reset mid-count -> all outputs 0 next cycle, counters restart.

Source files
------------

// File: rtl/game_tick_scheduler.sv
// game_tick_scheduler
// Detects one frame event per frame from the VGA scan position and derives
// NUM_CH independent periodic tick pulses with programmable periods (in frames).
// Supports pause, single-frame step while paused, per-channel disable
// (period 0) and a free-running frame counter.
module game_tick_scheduler #(
   parameter int BIT     = 10,
   parameter int V_EVENT = 490,
   parameter int H_EVENT = 656,
   parameter int NUM_CH  = 2,
   parameter int CNT_W   = 8,
   parameter int FRAME_W = 16
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [BIT-1:0]          x_pos,
   input  logic [BIT-1:0]          y_pos,
   input  logic [NUM_CH*CNT_W-1:0] period,
   input  logic                    pause,
   input  logic                    step,
   output logic                    frame_strobe,
   output logic [NUM_CH-1:0]       tick,
   output logic [FRAME_W-1:0]      frame_cnt
);

   localparam logic [BIT-1:0]     V_POS     = BIT'(V_EVENT);
   localparam logic [BIT-1:0]     H_POS     = BIT'(H_EVENT);
   localparam logic [CNT_W-1:0]   CNT_ZERO  = '0;
   localparam logic [CNT_W-1:0]   CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [FRAME_W-1:0] FRAME_ONE = {{(FRAME_W-1){1'b0}}, 1'b1};

   logic                    match;
   logic                    match_q;
   logic                    frame_evt;
   logic                    step_pending;
   logic                    step_pending_nxt;
   logic                    pend_eff;
   logic [CNT_W-1:0]        ch_period [NUM_CH];
   logic [CNT_W-1:0]        cnt       [NUM_CH];
   logic [CNT_W-1:0]        cnt_nxt   [NUM_CH];
   logic [NUM_CH-1:0]       tick_nxt;

   // Frame-event detection: rising edge of the coordinate match, so a position
   // held for several clocks still yields a single event.
   always_comb begin
      match     = (y_pos == V_POS) && (x_pos == H_POS);
      frame_evt = match & ~match_q;
   end

   // Step bookkeeping: a step while paused arms one pending step (no queueing);
   // it is consumed by the next frame event, and leaving pause discards it.
   always_comb begin
      pend_eff         = step_pending | step;
      step_pending_nxt = 1'b0;
      if (pause) begin
         if (frame_evt && pend_eff) begin
            step_pending_nxt = 1'b0;
         end else begin
            step_pending_nxt = pend_eff;
         end
      end else begin
         step_pending_nxt = 1'b0;
      end
   end

   // Slice the packed period bus into one period per channel.
   always_comb begin
      for (int i = 0; i < NUM_CH; i++) begin
         ch_period[i] = period[i*CNT_W +: CNT_W];
      end
   end

   // Per-channel counter/tick decision taken on each frame event.
   always_comb begin
      tick_nxt = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         cnt_nxt[i] = cnt[i];
         if (!frame_evt) begin
            cnt_nxt[i] = cnt[i];
         end else if (pause) begin
            if (pend_eff && (ch_period[i] != CNT_ZERO)) begin
               cnt_nxt[i]  = CNT_ZERO;
               tick_nxt[i] = 1'b1;
            end else begin
               cnt_nxt[i] = cnt[i];
            end
         end else begin
            if (ch_period[i] == CNT_ZERO) begin
               cnt_nxt[i] = CNT_ZERO;
            end else if (cnt[i] >= (ch_period[i] - CNT_ONE)) begin
               // Also catches a period lowered below the running count.
               cnt_nxt[i]  = CNT_ZERO;
               tick_nxt[i] = 1'b1;
            end else begin
               cnt_nxt[i] = cnt[i] + CNT_ONE;
            end
         end
      end
   end

   // State and output registers; match_q resets high so a position already
   // matching at reset release does not fire an event.
   always_ff @(posedge clk) begin
      if (reset) begin
         match_q      <= 1'b1;
         step_pending <= 1'b0;
         frame_strobe <= 1'b0;
         tick         <= '0;
         frame_cnt    <= '0;
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i] <= CNT_ZERO;
         end
      end else begin
         match_q      <= match;
         step_pending <= step_pending_nxt;
         frame_strobe <= frame_evt;
         tick         <= tick_nxt;
         if (frame_evt) begin
            frame_cnt <= frame_cnt + FRAME_ONE;
         end else begin
            frame_cnt <= frame_cnt;
         end
         for (int i = 0; i < NUM_CH; i++) begin
            cnt[i] <= cnt_nxt[i];
         end
      end
   end

endmodule

// File: tb/tb_game_tick_scheduler.sv
// Self-checking bench for game_tick_scheduler: hand sequences, a table of
// per-frame vectors, and randomized stimulus against a behavioural model.
module tb_game_tick_scheduler;

   logic        clk = 1'b0;
   logic        reset;
   logic [9:0]  x_pos, y_pos;
   logic [15:0] period;
   logic        pause, step;
   logic        frame_strobe;
   logic [1:0]  tick;
   logic [15:0] frame_cnt;
   logic        frame_strobe4;
   logic [1:0]  tick4;
   logic [3:0]  frame_cnt4;

   always #5 clk = ~clk;

   game_tick_scheduler dut (
      .clk(clk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos), .period(period),
      .pause(pause), .step(step), .frame_strobe(frame_strobe), .tick(tick),
      .frame_cnt(frame_cnt));

   game_tick_scheduler #(.FRAME_W(4)) dut4 (
      .clk(clk), .reset(reset), .x_pos(x_pos), .y_pos(y_pos), .period(period),
      .pause(pause), .step(step), .frame_strobe(frame_strobe4), .tick(tick4),
      .frame_cnt(frame_cnt4));

   // behavioural model state
   bit       m_prev;
   int       m_cnt [2];
   bit       m_pend;
   int       m_frame;
   bit       m_strobe;
   bit [1:0] m_tick;

   int       total_cnt = 0;
   int       pass_cnt  = 0;
   bit [1:0] seen_tick;
   int       strobe_seen;

   typedef struct {
      int       p0;
      int       p1;
      bit       pse;
      int       nsteps;
      bit [1:0] exp_tick;
      int       exp_frame;
   } vec_t;
   vec_t tbl [20];

   task automatic chk(input string name, input int act, input int exp);
      total_cnt++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Model of one clock edge, straight from the behavioural rules.
   task automatic model_step();
      bit match, evt, pe;
      int p;
      m_tick = 2'b00;
      if (reset) begin
         m_prev = 1'b1; m_pend = 1'b0; m_frame = 0; m_strobe = 1'b0;
         m_cnt[0] = 0; m_cnt[1] = 0;
         return;
      end
      match  = (x_pos == 10'd656) && (y_pos == 10'd490);
      evt    = match && !m_prev;
      m_prev = match;
      m_strobe = evt;
      if (evt) m_frame = m_frame + 1;
      if (pause) begin
         pe = m_pend || step;
         if (evt && pe) begin
            for (int i = 0; i < 2; i++) begin
               p = int'(period[i*8 +: 8]);
               if (p > 0) begin m_tick[i] = 1'b1; m_cnt[i] = 0; end
            end
            m_pend = 1'b0;
         end else begin
            m_pend = pe;
         end
      end else begin
         m_pend = 1'b0;
         if (evt) begin
            for (int i = 0; i < 2; i++) begin
               p = int'(period[i*8 +: 8]);
               if (p == 0) m_cnt[i] = 0;
               else if (m_cnt[i] + 1 >= p) begin m_tick[i] = 1'b1; m_cnt[i] = 0; end
               else m_cnt[i] = m_cnt[i] + 1;
            end
         end
      end
   endtask

   task automatic tick_clk();
      @(posedge clk);
      model_step();
      #1;
      chk("strobe",     int'(frame_strobe),  int'(m_strobe));
      chk("tick",       int'(tick),          int'(m_tick));
      chk("frame_cnt",  int'(frame_cnt),     m_frame % 65536);
      chk("strobe_w4",  int'(frame_strobe4), int'(m_strobe));
      chk("tick_w4",    int'(tick4),         int'(m_tick));
      chk("frame_cnt4", int'(frame_cnt4),    m_frame % 16);
      seen_tick   |= tick;
      strobe_seen += int'(frame_strobe);
   endtask

   task automatic coords_on();  x_pos = 10'd656; y_pos = 10'd490; endtask
   task automatic coords_off(); x_pos = 10'd100; y_pos = 10'd200; endtask

   task automatic do_frame(input int p0, input int p1, input bit pse, input int nsteps);
      period = {8'(p1), 8'(p0)};
      pause  = pse;
      coords_off();
      tick_clk();
      seen_tick = 2'b00;
      for (int k = 0; k < nsteps; k++) begin
         step = 1'b1; tick_clk();
         step = 1'b0; tick_clk();
      end
      coords_on();  tick_clk();
      coords_off(); tick_clk(); tick_clk();
   endtask

   task automatic do_reset();
      reset = 1'b1; tick_clk(); tick_clk();
      reset = 1'b0;
   endtask

   initial begin
      tbl[0]  = '{2,0,1'b0,0,2'b00,1};
      tbl[1]  = '{2,0,1'b0,0,2'b01,2};
      tbl[2]  = '{2,0,1'b0,0,2'b00,3};
      tbl[3]  = '{2,0,1'b0,0,2'b01,4};
      tbl[4]  = '{2,0,1'b0,0,2'b00,5};
      tbl[5]  = '{2,0,1'b0,0,2'b01,6};
      tbl[6]  = '{5,3,1'b0,0,2'b00,7};
      tbl[7]  = '{5,3,1'b0,0,2'b00,8};
      tbl[8]  = '{5,3,1'b0,0,2'b10,9};
      tbl[9]  = '{1,3,1'b0,0,2'b01,10};
      tbl[10] = '{1,3,1'b0,0,2'b01,11};
      tbl[11] = '{1,3,1'b0,0,2'b11,12};
      tbl[12] = '{1,3,1'b1,0,2'b00,13};
      tbl[13] = '{1,3,1'b1,0,2'b00,14};
      tbl[14] = '{1,3,1'b1,0,2'b00,15};
      tbl[15] = '{1,3,1'b1,2,2'b11,16};
      tbl[16] = '{1,3,1'b1,0,2'b00,17};
      tbl[17] = '{1,3,1'b0,1,2'b01,18};
      tbl[18] = '{1,0,1'b1,1,2'b01,19};
      tbl[19] = '{1,0,1'b0,0,2'b01,20};

      reset = 1'b1; pause = 1'b0; step = 1'b0; period = 16'h0000;
      coords_on();

      // Reset with coordinates matching, then release: no strobe.
      tick_clk(); tick_clk();
      chk("reset_strobe", int'(frame_strobe), 0);
      chk("reset_cnt",    int'(frame_cnt),    0);
      reset = 1'b0;
      strobe_seen = 0;
      tick_clk(); tick_clk(); tick_clk();
      chk("held_at_release", strobe_seen, 0);
      coords_off(); tick_clk();
      coords_on();  tick_clk();
      chk("return_strobe", int'(frame_strobe), 1);
      chk("return_cnt",    int'(frame_cnt),    1);

      // Coordinates held 4 clocks: exactly one strobe, in the first cycle after.
      coords_off(); tick_clk();
      coords_on();  strobe_seen = 0;
      tick_clk();
      chk("hold_first", int'(frame_strobe), 1);
      tick_clk(); tick_clk(); tick_clk();
      coords_off(); tick_clk();
      chk("hold_count", strobe_seen, 1);
      chk("hold_frame", int'(frame_cnt), 2);

      // Table-driven frames.
      do_reset();
      for (int v = 0; v < 20; v++) begin
         do_frame(tbl[v].p0, tbl[v].p1, tbl[v].pse, tbl[v].nsteps);
         chk($sformatf("tbl%0d_tick", v),  int'(seen_tick), int'(tbl[v].exp_tick));
         chk($sformatf("tbl%0d_frame", v), int'(frame_cnt), tbl[v].exp_frame);
      end

      // 4-bit frame counter wraps: 17 events -> 1.
      do_reset();
      for (int f = 0; f < 17; f++) do_frame(2, 1, 1'b0, 0);
      chk("wrap_w4",  int'(frame_cnt4), 1);
      chk("wrap_w16", int'(frame_cnt),  17);

      // Reset mid-count in the same cycle as a match edge.
      coords_off(); tick_clk();
      coords_on(); reset = 1'b1; tick_clk();
      chk("mid_reset_strobe", int'(frame_strobe), 0);
      chk("mid_reset_tick",   int'(tick),         0);
      chk("mid_reset_cnt",    int'(frame_cnt),    0);
      reset = 1'b0;
      do_frame(2, 1, 1'b0, 0);
      chk("restart_tick1", int'(seen_tick), 2);
      do_frame(2, 1, 1'b0, 0);
      chk("restart_tick2", int'(seen_tick), 3);
      chk("restart_cnt",   int'(frame_cnt), 2);

      // Randomized stimulus against the model.
      pause = 1'b0;
      for (int c = 0; c < 4000; c++) begin
         reset = ($urandom_range(0, 599) == 0);
         if ($urandom_range(0, 39) == 0) pause = ~pause;
         step = ($urandom_range(0, 9) == 0);
         if ($urandom_range(0, 49) == 0)
            period = {8'($urandom_range(0, 4)), 8'($urandom_range(0, 4))};
         if ($urandom_range(0, 1) == 0) begin
            case ($urandom_range(0, 3))
               0: coords_on();
               1: begin x_pos = 10'd655; y_pos = 10'd490; end
               2: begin x_pos = 10'd656; y_pos = 10'd489; end
               default: begin x_pos = 10'($urandom); y_pos = 10'($urandom); end
            endcase
         end
         tick_clk();
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
